// File: rtl/neuron_buffer_swap_ctrl.sv
// Ping-pong neuron buffer sequencer: read/write address streams per layer,
// buffer-select flip once both streams complete.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   start                   begin a layer (honoured in IDLE only)
//   readCount, writeCount   per-layer word counts (A+1 bits), latched on start
//   readStep, writeStep     consumer took a read word / pool word is valid
//   readBufferSelect        0: read N1 / write N2, 1: reverse
//   readBuffAddress         registered read address
//   writeBuffAddress        registered write address
//   writeEnable             combinational write strobe
//   readDone                every read of the layer has been issued
//   busy                    high in RUN and SWAP
//   layerDone               one-cycle pulse in SWAP
//   overrun                 sticky: a writeStep arrived with no write allowed
module neuron_buffer_swap_ctrl #(
  parameter int A = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A:0]   readCount,
  input  logic [A:0]   writeCount,
  input  logic         readStep,
  input  logic         writeStep,
  output logic         readBufferSelect,
  output logic [A-1:0] readBuffAddress,
  output logic [A-1:0] writeBuffAddress,
  output logic         writeEnable,
  output logic         readDone,
  output logic         busy,
  output logic         layerDone,
  output logic         overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [A:0] rcnt;
  logic [A:0] wcnt;
  logic [A:0] ridx;
  logic [A:0] widx;
  logic       sel;
  logic       ovr;

  logic       rd_all;
  logic       wr_all;
  logic       rd_ok;
  logic       accept;

  assign rd_all = (ridx == rcnt);
  assign wr_all = (widx == wcnt);
  assign rd_ok  = (state == RUN) && readStep && (ridx < rcnt);
  assign accept = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: completion judged on registered indices only
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (rd_all && wr_all) state_nx = SWAP;
      SWAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = 1'b0;
    layerDone   = 1'b0;
    writeEnable = 1'b0;
    readDone    = 1'b0;
    unique case (state)
      IDLE: ;
      RUN: begin
        busy        = 1'b1;
        writeEnable = writeStep && (widx < wcnt);
        readDone    = rd_all;
      end
      SWAP: begin
        busy      = 1'b1;
        layerDone = 1'b1;
        readDone  = rd_all;
      end
      default: ;
    endcase
  end

  // Counters, select and sticky overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      wcnt <= '0;
      ridx <= '0;
      widx <= '0;
      sel  <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (accept) begin
        rcnt <= readCount;
        wcnt <= writeCount;
        ridx <= '0;
        widx <= '0;
        ovr  <= 1'b0;
      end else begin
        if (rd_ok)       ridx <= ridx + 1'b1;
        if (writeEnable) widx <= widx + 1'b1;
        // any write step that cannot be written is an overrun
        if (writeStep && !writeEnable) ovr <= 1'b1;
      end
      if (state == SWAP) sel <= ~sel;
    end
  end

  // Addresses are the low bits: a full 2^A count wraps back to 0
  assign readBuffAddress  = ridx[A-1:0];
  assign writeBuffAddress = widx[A-1:0];
  assign readBufferSelect = sel;
  assign overrun          = ovr;

endmodule

// File: tb/tb_neuron_buffer_swap_ctrl.sv
// Directed testbench for neuron_buffer_swap_ctrl: per-cycle vector table
// plus hand sequences for address wrap and asynchronous mid-run reset.
module tb_neuron_buffer_swap_ctrl;

  localparam int A = 7;

  logic         clk;
  logic         reset;
  logic         start;
  logic [A:0]   readCount;
  logic [A:0]   writeCount;
  logic         readStep;
  logic         writeStep;
  logic         readBufferSelect;
  logic [A-1:0] readBuffAddress;
  logic [A-1:0] writeBuffAddress;
  logic         writeEnable;
  logic         readDone;
  logic         busy;
  logic         layerDone;
  logic         overrun;

  neuron_buffer_swap_ctrl #(.A(A)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .readCount        (readCount),
    .writeCount       (writeCount),
    .readStep         (readStep),
    .writeStep        (writeStep),
    .readBufferSelect (readBufferSelect),
    .readBuffAddress  (readBuffAddress),
    .writeBuffAddress (writeBuffAddress),
    .writeEnable      (writeEnable),
    .readDone         (readDone),
    .busy             (busy),
    .layerDone        (layerDone),
    .overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [A:0] rc;
    logic [A:0] wc;
    logic       rs;
    logic       ws;
    logic [19:0] exp;
  } vec_t;

  vec_t vq[$];
  int nvec;
  int nerr;

  function automatic logic [19:0] pk(
    input logic sel, input logic [A-1:0] ra, input logic [A-1:0] wa,
    input logic we, input logic rd, input logic bz, input logic ld,
    input logic ov);
    return {sel, ra, wa, we, rd, bz, ld, ov};
  endfunction

  task automatic add(
    input logic st, input int rc, input int wc, input logic rs,
    input logic ws, input logic sel, input int ra, input int wa,
    input logic we, input logic rd, input logic bz, input logic ld,
    input logic ov);
    vec_t v;
    v.st  = st;
    v.rc  = rc[A:0];
    v.wc  = wc[A:0];
    v.rs  = rs;
    v.ws  = ws;
    v.exp = pk(sel, ra[A-1:0], wa[A-1:0], we, rd, bz, ld, ov);
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [19:0] exp);
    logic [19:0] act;
    act = pk(readBufferSelect, readBuffAddress, writeBuffAddress,
             writeEnable, readDone, busy, layerDone, overrun);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got sel/ra/wa/we/rd/bz/ld/ov=%0b/%0d/%0d/%0b%0b%0b%0b%0b want %0b/%0d/%0d/%0b%0b%0b%0b%0b",
        name, act[19], act[18:12], act[11:5], act[4], act[3], act[2],
        act[1], act[0], exp[19], exp[18:12], exp[11:5], exp[4], exp[3],
        exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic st, input logic [A:0] rc,
                       input logic [A:0] wc, input logic rs,
                       input logic ws);
    start      = st;
    readCount  = rc;
    writeCount = wc;
    readStep   = rs;
    writeStep  = ws;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    //      st rc wc rs ws | sel ra wa we rd bz ld ov
    // basic layer 4 reads / 2 writes
    add(1, 4, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4, 2, 1, 0,  0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 4, 2, 1, 1,  0, 1, 0, 1, 0, 1, 0, 0);
    add(0, 4, 2, 1, 1,  0, 2, 1, 1, 0, 1, 0, 0);
    add(0, 4, 2, 1, 0,  0, 3, 2, 0, 0, 1, 0, 0);
    add(0, 4, 2, 0, 0,  0, 4, 2, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  0, 4, 2, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0,  1, 4, 2, 0, 0, 0, 0, 0);
    // second layer, start with other counts during RUN is ignored
    add(1, 4, 2, 0, 0,  1, 4, 2, 0, 0, 0, 0, 0);
    add(1, 9, 9, 1, 1,  1, 0, 0, 1, 0, 1, 0, 0);
    add(1, 9, 9, 1, 1,  1, 1, 1, 1, 0, 1, 0, 0);
    add(1, 9, 9, 1, 0,  1, 2, 2, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0,  1, 3, 2, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 4, 2, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 4, 2, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0,  0, 4, 2, 0, 0, 0, 0, 0);
    // zero counts: minimum layer
    add(1, 0, 0, 0, 0,  0, 4, 2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    // overrun in RUN, sticky until next start
    add(1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1,  1, 0, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1,  1, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    // overrun from a write step in IDLE
    add(0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);

    // asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #2 chk("reset_async", pk(0, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].st, vq[i].rc, vq[i].wc, vq[i].rs, vq[i].ws);
      @(negedge clk);
      chk($sformatf("row%0d", i), vq[i].exp);
      step();
    end

    // full 2^A read count: address wraps to 0, extra step ignored
    drive(1'b1, 8'd128, 8'd0, 1'b0, 1'b0);
    step();
    start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      readStep = 1'b1;
      @(negedge clk);
      chk($sformatf("wrap_rd%0d", i),
          pk(0, i[A-1:0], 0, 0, 0, 1, 0, 0));
      step();
    end
    @(negedge clk);
    chk("wrap_done", pk(0, 0, 0, 0, 1, 1, 0, 0));
    step();
    readStep = 1'b0;
    @(negedge clk);
    chk("wrap_swap", pk(0, 0, 0, 0, 1, 1, 1, 0));
    step();
    @(negedge clk);
    chk("wrap_idle", pk(1, 0, 0, 0, 0, 0, 0, 0));
    step();

    // reset mid-run after 3 of 8 reads
    drive(1'b1, 8'd8, 8'd8, 1'b0, 1'b0);
    step();
    start = 1'b0;
    readStep = 1'b1;
    step();
    step();
    step();
    readStep = 1'b0;
    @(negedge clk);
    chk("midrun_pre", pk(1, 3, 0, 0, 0, 1, 0, 0));
    step();
    #2 reset = 1'b1;
    #1 chk("midrun_async", pk(0, 0, 0, 0, 0, 0, 0, 0));
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", i), pk(0, 0, 0, 0, 0, 0, 0, 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
